image_skin_bbox: RTL and testbench

Downstream stage of the RGB888→YCbCr444 converter. Classifies each YCbCr pixel as skin/non-skin using inclusive Cb/Cr windows. Emits a 1-bit mask stream with delayed sync signals, and accumulates a per-frame bounding box and skin-pixel count. These are published one cycle after each frame ends. Feeds the mask into the binary morphology stages and the box into the overlay/tracking logic.

---
 rtl/image_skin_bbox.sv | 197 +++++++++++++++++++
 tb/tb_image_skin_bbox.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_skin_bbox.sv
`default_nettype none
// ============================================================================
// image_skin_bbox : YCbCr skin classifier with per-frame bounding box/count
// Rev 1.0
// ============================================================================
module image_skin_bbox #(
  parameter logic [7:0] CB_MIN = 8'd77,
  parameter logic [7:0] CB_MAX = 8'd127,
  parameter logic [7:0] CR_MIN = 8'd133,
  parameter logic [7:0] CR_MAX = 8'd173
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_Y,
  input  logic [7:0]  per_img_Cb,
  input  logic [7:0]  per_img_Cr,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic        post_img_bit,
  output logic        box_valid,
  output logic        box_empty,
  output logic [10:0] box_xmin,
  output logic [10:0] box_xmax,
  output logic [10:0] box_ymin,
  output logic [10:0] box_ymax,
  output logic [19:0] skin_cnt
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  localparam logic [10:0] c_coord_max = 11'd2047;
  localparam logic [19:0] c_cnt_max   = 20'hFFFFF;

  state_t      r_state, w_state_next;
  logic        r_vsync, r_href, r_clken, r_bit, r_armed;
  logic [10:0] r_x_cnt, r_y_cnt;
  logic [10:0] r_xmin, r_xmax, r_ymin, r_ymax;
  logic [19:0] r_cnt;
  logic        r_box_valid, r_box_empty;
  logic [10:0] r_box_xmin, r_box_xmax, r_box_ymin, r_box_ymax;
  logic [19:0] r_skin_cnt;

  logic        w_valid, w_skin, w_acc_en, w_start, w_publish;
  logic        w_vs_rise, w_vs_fall, w_hr_rise, w_hr_fall;
  logic [10:0] w_x, w_y;
  logic [10:0] w_xmin_b, w_xmax_b, w_ymin_b, w_ymax_b;
  logic [19:0] w_cnt_b;
  logic        w_unused_y;

  assign w_unused_y = ^per_img_Y;

  assign w_valid   = per_frame_vsync & per_frame_href & per_frame_clken;
  assign w_skin    = (per_img_Cb >= CB_MIN) && (per_img_Cb <= CB_MAX) &&
                     (per_img_Cr >= CR_MIN) && (per_img_Cr <= CR_MAX);
  assign w_vs_rise = per_frame_vsync & ~r_vsync;
  assign w_vs_fall = ~per_frame_vsync & r_vsync;
  assign w_hr_rise = per_frame_href & ~r_href;
  assign w_hr_fall = ~per_frame_href & r_href;
  assign w_x       = w_hr_rise ? 11'd0 : r_x_cnt;
  assign w_y       = w_vs_rise ? 11'd0 : r_y_cnt;

  // r_armed blocks a false rising edge when reset releases in the middle of a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync <= 1'b0;
      r_href  <= 1'b0;
      r_clken <= 1'b0;
      r_bit   <= 1'b0;
      r_armed <= ~per_frame_vsync;
    end else begin
      r_vsync <= per_frame_vsync;
      r_href  <= per_frame_href;
      r_clken <= per_frame_clken;
      r_bit   <= w_valid & w_skin;
      if (!per_frame_vsync) r_armed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x_cnt <= 11'd0;
      r_y_cnt <= 11'd0;
    end else begin
      if (w_valid)
        r_x_cnt <= (w_x == c_coord_max) ? c_coord_max : w_x + 11'd1;
      else if (w_hr_rise)
        r_x_cnt <= 11'd0;

      if (w_vs_rise)
        r_y_cnt <= 11'd0;
      else if (w_hr_fall && per_frame_vsync && (r_y_cnt != c_coord_max))
        r_y_cnt <= r_y_cnt + 11'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_publish    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vs_rise && r_armed) begin
          w_start      = 1'b1;
          w_state_next = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_vs_fall) begin
          w_publish    = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // A pixel in the frame-start cycle folds into the freshly initialised accumulators.
  assign w_acc_en = w_valid & w_skin & (w_start | (r_state == S_ACTIVE));
  assign w_xmin_b = w_start ? c_coord_max : r_xmin;
  assign w_xmax_b = w_start ? 11'd0       : r_xmax;
  assign w_ymin_b = w_start ? c_coord_max : r_ymin;
  assign w_ymax_b = w_start ? 11'd0       : r_ymax;
  assign w_cnt_b  = w_start ? 20'd0       : r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_xmin <= c_coord_max;
      r_xmax <= 11'd0;
      r_ymin <= c_coord_max;
      r_ymax <= 11'd0;
      r_cnt  <= 20'd0;
    end else if (w_start || w_acc_en) begin
      r_xmin <= (w_acc_en && (w_x < w_xmin_b)) ? w_x : w_xmin_b;
      r_xmax <= (w_acc_en && (w_x > w_xmax_b)) ? w_x : w_xmax_b;
      r_ymin <= (w_acc_en && (w_y < w_ymin_b)) ? w_y : w_ymin_b;
      r_ymax <= (w_acc_en && (w_y > w_ymax_b)) ? w_y : w_ymax_b;
      r_cnt  <= (w_acc_en && (w_cnt_b != c_cnt_max)) ? w_cnt_b + 20'd1 : w_cnt_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_box_valid <= 1'b0;
      r_box_empty <= 1'b1;
      r_box_xmin  <= 11'd0;
      r_box_xmax  <= 11'd0;
      r_box_ymin  <= 11'd0;
      r_box_ymax  <= 11'd0;
      r_skin_cnt  <= 20'd0;
    end else begin
      r_box_valid <= w_publish;
      if (w_publish) begin
        if (r_cnt == 20'd0) begin
          r_box_empty <= 1'b1;
          r_box_xmin  <= 11'd0;
          r_box_xmax  <= 11'd0;
          r_box_ymin  <= 11'd0;
          r_box_ymax  <= 11'd0;
          r_skin_cnt  <= 20'd0;
        end else begin
          r_box_empty <= 1'b0;
          r_box_xmin  <= r_xmin;
          r_box_xmax  <= r_xmax;
          r_box_ymin  <= r_ymin;
          r_box_ymax  <= r_ymax;
          r_skin_cnt  <= r_cnt;
        end
      end
    end
  end

  assign post_frame_vsync = r_vsync;
  assign post_frame_href  = r_href;
  assign post_frame_clken = r_clken;
  assign post_img_bit     = r_bit;
  assign box_valid        = r_box_valid;
  assign box_empty        = r_box_empty;
  assign box_xmin         = r_box_xmin;
  assign box_xmax         = r_box_xmax;
  assign box_ymin         = r_box_ymin;
  assign box_ymax         = r_box_ymax;
  assign skin_cnt         = r_skin_cnt;

endmodule
`default_nettype wire

// File: tb/tb_image_skin_bbox.sv
`default_nettype none
// ============================================================================
// tb_image_skin_bbox : bench for image_skin_bbox with a positional frame model
// Rev 1.0
// ============================================================================
module tb_image_skin_bbox;

  logic        clk = 1'b0;
  logic        rst;
  logic        per_frame_vsync, per_frame_href, per_frame_clken;
  logic [7:0]  per_img_Y, per_img_Cb, per_img_Cr;
  logic        post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit;
  logic        box_valid, box_empty;
  logic [10:0] box_xmin, box_xmax, box_ymin, box_ymax;
  logic [19:0] skin_cnt;

  image_skin_bbox dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_img_Y(per_img_Y),
    .per_img_Cb(per_img_Cb), .per_img_Cr(per_img_Cr),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_img_bit(post_img_bit),
    .box_valid(box_valid), .box_empty(box_empty),
    .box_xmin(box_xmin), .box_xmax(box_xmax), .box_ymin(box_ymin), .box_ymax(box_ymax),
    .skin_cnt(skin_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] cb;
    logic [7:0] cr;
    logic       exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int f_w, f_h;
  logic [7:0] f_cb [0:15][0:15];
  logic [7:0] f_cr [0:15][0:15];
  vec_t tbl [0:7];

  function automatic bit is_skin(input logic [7:0] cb, input logic [7:0] cr);
    return (cb >= 8'd77) && (cb <= 8'd127) && (cr >= 8'd133) && (cr <= 8'd173);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, then check the registered response 1 ns after the edge.
  task automatic cyc(input logic v, input logic h, input logic c,
                     input logic [7:0] cb, input logic [7:0] cr, input logic exp_bv);
    per_frame_vsync = v;
    per_frame_href  = h;
    per_frame_clken = c;
    per_img_Cb      = cb;
    per_img_Cr      = cr;
    per_img_Y       = 8'($urandom);
    @(posedge clk);
    #1;
    chk("post_sync", {post_frame_vsync, post_frame_href, post_frame_clken},
        rst ? 3'b000 : {v, h, c});
    chk("mask", post_img_bit, !rst && v && h && c && is_skin(cb, cr));
    chk("box_valid", box_valid, exp_bv);
  endtask

  task automatic check_box(input logic e, input int xmin, input int xmax,
                           input int ymin, input int ymax, input int cnt);
    chk("box_empty", box_empty, e);
    chk("box_xmin", box_xmin, xmin);
    chk("box_xmax", box_xmax, xmax);
    chk("box_ymin", box_ymin, ymin);
    chk("box_ymax", box_ymax, ymax);
    chk("skin_cnt", skin_cnt, cnt);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b1, 1'b1, 8'd100, 8'd150, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic fill_const(input int w, input int h, input logic [7:0] cb, input logic [7:0] cr);
    f_w = w;
    f_h = h;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        f_cb[r][c] = cb;
        f_cr[r][c] = cr;
      end
  endtask

  task automatic fill_random(input int w, input int h);
    fill_const(w, h, 8'd0, 8'd0);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        if ($urandom_range(0, 9) < 3) begin
          f_cb[r][c] = 8'($urandom_range(77, 127));
          f_cr[r][c] = 8'($urandom_range(133, 173));
        end else begin
          f_cb[r][c] = 8'($urandom);
          f_cr[r][c] = 8'($urandom);
        end
      end
  endtask

  // Box expectation comes from pixel positions alone: x = column, y = row.
  task automatic run_frame(input bit gaps, input bit exp_pub);
    int exmin = 2047, exmax = 0, eymin = 2047, eymax = 0, ecnt = 0;
    for (int r = 0; r < f_h; r++)
      for (int c = 0; c < f_w; c++)
        if (is_skin(f_cb[r][c], f_cr[r][c])) begin
          ecnt++;
          if (c < exmin) exmin = c;
          if (c > exmax) exmax = c;
          if (r < eymin) eymin = r;
          if (r > eymax) eymax = r;
        end
    cyc(1'b1, 1'b0, 1'b0, 8'd100, 8'd150, 1'b0);
    for (int r = 0; r < f_h; r++) begin
      for (int c = 0; c < f_w; c++) begin
        if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b1, 1'b1, 1'b0, 8'd100, 8'd150, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, f_cb[r][c], f_cr[r][c], 1'b0);
      end
      repeat ($urandom_range(1, 2)) cyc(1'b1, 1'b0, 1'b0, 8'd100, 8'd150, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, exp_pub);
    if (exp_pub) begin
      if (ecnt == 0) check_box(1'b1, 0, 0, 0, 0, 0);
      else           check_box(1'b0, exmin, exmax, eymin, eymax, ecnt);
    end
  endtask

  initial begin
    int tcnt, txmin, txmax;
    rst = 1'b1;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    per_frame_clken = 1'b0;
    per_img_Y  = 8'd0;
    per_img_Cb = 8'd0;
    per_img_Cr = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sync", {post_frame_vsync, post_frame_href, post_frame_clken}, 3'b000);
    chk("rst_mask", post_img_bit, 1'b0);
    chk("rst_box_valid", box_valid, 1'b0);
    check_box(1'b1, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // 4x3 directed frame
    idle(2);
    fill_const(4, 3, 8'd128, 8'd128);
    f_cb[0][1] = 8'd100; f_cr[0][1] = 8'd150;
    f_cb[2][2] = 8'd100; f_cr[2][2] = 8'd150;
    run_frame(1'b0, 1'b1);
    check_box(1'b0, 1, 2, 0, 2, 2);

    // Window boundaries in a single line
    tbl[0] = '{8'd77,  8'd133, 1'b1};
    tbl[1] = '{8'd127, 8'd173, 1'b1};
    tbl[2] = '{8'd76,  8'd150, 1'b0};
    tbl[3] = '{8'd100, 8'd174, 1'b0};
    tbl[4] = '{8'd128, 8'd150, 1'b0};
    tbl[5] = '{8'd100, 8'd132, 1'b0};
    tbl[6] = '{8'd100, 8'd150, 1'b1};
    tbl[7] = '{8'd128, 8'd128, 1'b0};
    idle(1);
    tcnt = 0; txmin = 2047; txmax = 0;
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b1, tbl[i].cb, tbl[i].cr, 1'b0);
      chk("tbl_mask", post_img_bit, tbl[i].exp);
      if (tbl[i].exp) begin
        tcnt++;
        if (i < txmin) txmin = i;
        if (i > txmax) txmax = i;
      end
    end
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check_box(1'b0, txmin, txmax, 0, 0, tcnt);

    // No skin at all
    idle(2);
    fill_const(5, 2, 8'd128, 8'd128);
    run_frame(1'b0, 1'b1);
    check_box(1'b1, 0, 0, 0, 0, 0);

    // clken gaps carrying skin values
    idle(1);
    fill_random(9, 4);
    run_frame(1'b1, 1'b1);

    // vsync rise, href rise and a skin pixel in the same cycle
    idle(2);
    cyc(1'b1, 1'b1, 1'b1, 8'd100, 8'd150, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1);
    check_box(1'b0, 0, 0, 0, 0, 1);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    check_box(1'b0, 0, 0, 0, 0, 1);

    // Reset in the middle of a frame, vsync still high on release
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 8'd100, 8'd150, 1'b0);
    rst = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, 1'b1, 8'd100, 8'd150, 1'b0);
    check_box(1'b1, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (3) cyc(1'b1, 1'b1, 1'b1, 8'd100, 8'd150, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 8'd90, 8'd140, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    check_box(1'b1, 0, 0, 0, 0, 0);
    fill_random(6, 3);
    f_cb[1][2] = 8'd100; f_cr[1][2] = 8'd150;
    run_frame(1'b0, 1'b1);

    // Back-to-back frames with different skin positions
    idle(1);
    fill_const(6, 4, 8'd128, 8'd128);
    f_cb[0][5] = 8'd90; f_cr[0][5] = 8'd160;
    f_cb[1][4] = 8'd90; f_cr[1][4] = 8'd160;
    run_frame(1'b0, 1'b1);
    check_box(1'b0, 4, 5, 0, 1, 2);
    fill_const(6, 4, 8'd128, 8'd128);
    f_cb[3][0] = 8'd120; f_cr[3][0] = 8'd140;
    run_frame(1'b0, 1'b1);
    check_box(1'b0, 0, 0, 3, 3, 1);

    // Random frames
    for (int k = 0; k < 8; k++) begin
      idle($urandom_range(0, 3));
      fill_random($urandom_range(1, 12), $urandom_range(1, 6));
      run_frame(1'($urandom_range(0, 1)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
